// File: rtl/kbd_uart_rx.sv
// 8N1 UART receiver that turns one-byte supervisor commands into the CPC 80-key
// active-low keyboard matrix. The supervisor sends key press, key release and release-all codes.
module kbd_uart_rx #(
    parameter int unsigned DIVISOR = 139
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        uart_rx_i,
    output logic [79:0] keyboard_o,
    output logic [7:0]  rx_byte_o,
    output logic        rx_valid_o,
    output logic        frame_err_o
);

    localparam logic [11:0] DivFull = 12'(DIVISOR);
    localparam logic [11:0] DivHalf = 12'(DIVISOR / 2);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        accept_q, accept_d;
    logic [79:0] keyboard_q, keyboard_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;

    logic rxs;
    logic expire;

    assign rxs    = sync2_q;
    assign expire = (cnt_q == 12'd1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            accept_q    <= 1'b0;
            keyboard_q  <= '1;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= uart_rx_i;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            accept_q    <= accept_d;
            keyboard_q  <= keyboard_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        accept_d    = 1'b0;
        frame_err_d = 1'b0;

        // Counter runs in every bit-timing state; expiry is the cycle it reads 1.
        if ((state_q == StStart || state_q == StData || state_q == StStop) && !expire) begin
            cnt_d = cnt_q - 12'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (!rxs) begin
                    cnt_d   = DivHalf;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (expire) begin
                    if (rxs) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d     = DivFull;
                        bit_idx_d = '0;
                        state_d   = StData;
                    end
                end
            end
            StData: begin
                if (expire) begin
                    shift_d[bit_idx_q] = rxs;
                    cnt_d              = DivFull;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (expire) begin
                    if (rxs) begin
                        accept_d = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Accepted byte is decoded one edge after the stop-bit sample.
    always_comb begin
        keyboard_d = keyboard_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        if (accept_q) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = shift_q;
            if (shift_q[6:0] == 7'h7F) begin
                keyboard_d = '1;
            end else if (shift_q[6:0] < 7'd80) begin
                keyboard_d[shift_q[6:0]] = shift_q[7];
            end
        end
    end

    assign keyboard_o  = keyboard_q;
    assign rx_byte_o   = rx_byte_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_kbd_uart_rx.sv
// Directed bench for kbd_uart_rx with DIVISOR = 16: key press/release, release-all,
// framing error, glitch rejection, back-to-back frames and mid-frame reset.
module tb_kbd_uart_rx;

    localparam int Div = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line = 1'b1;
    logic [79:0] keyboard;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        frame_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int valid_cnt    = 0;
    int err_cnt      = 0;
    int overlap_cnt  = 0;
    logic [7:0] log_q [32];

    kbd_uart_rx #(.DIVISOR(Div)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .uart_rx_i  (line),
        .keyboard_o (keyboard),
        .rx_byte_o  (rx_byte),
        .rx_valid_o (rx_valid),
        .frame_err_o(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            if (valid_cnt < 32) log_q[valid_cnt] = rx_byte;
            valid_cnt = valid_cnt + 1;
        end
        if (frame_err) err_cnt = err_cnt + 1;
        if (rx_valid && frame_err) overlap_cnt = overlap_cnt + 1;
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        line = 1'b0;
        repeat (Div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            repeat (Div) @(negedge clk);
        end
        line = stop_bit;
        repeat (Div) @(negedge clk);
    endtask

    function automatic logic [79:0] pressed(input logic [79:0] mask);
        return ~mask;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_kbd", keyboard, '1);
        check("reset_byte", 80'(rx_byte), 80'h00);
        check("reset_valid", 80'(rx_valid), 80'd0);
        check("reset_err", 80'(frame_err), 80'd0);

        // Single press
        idle(4);
        send(8'h05, 1'b1);
        idle(4);
        check("p05_cnt", 80'(valid_cnt), 80'd1);
        check("p05_byte", 80'(rx_byte), 80'h05);
        check("p05_kbd", keyboard, pressed(80'd1 << 5));

        // Press 0x4F, release 0x05
        send(8'h4F, 1'b1);
        idle(4);
        check("p4f_cnt", 80'(valid_cnt), 80'd2);
        check("p4f_kbd", keyboard, pressed((80'd1 << 5) | (80'd1 << 79)));
        send(8'h85, 1'b1);
        idle(4);
        check("r85_cnt", 80'(valid_cnt), 80'd3);
        check("r85_byte", 80'(rx_byte), 80'h85);
        check("r85_kbd", keyboard, pressed(80'd1 << 79));
        check("r85_err", 80'(err_cnt), 80'd0);

        // Release all
        send(8'h00, 1'b1);
        send(8'h20, 1'b1);
        idle(4);
        check("p00_20_kbd", keyboard, pressed((80'd1 << 79) | (80'd1 << 0) | (80'd1 << 32)));
        send(8'hFF, 1'b1);
        idle(4);
        check("ff_kbd", keyboard, '1);
        check("ff_byte", 80'(rx_byte), 80'hFF);
        check("ff_cnt", 80'(valid_cnt), 80'd6);

        // Framing error then held-low line, then a good frame
        send(8'hAA, 1'b0);
        line = 1'b0;
        repeat (40) @(negedge clk);
        check("brk_nopulse", 80'(valid_cnt), 80'd6);
        idle(20);
        send(8'h10, 1'b1);
        idle(4);
        check("brk_err", 80'(err_cnt), 80'd1);
        check("brk_cnt", 80'(valid_cnt), 80'd7);
        check("p10_byte", 80'(rx_byte), 80'h10);
        check("p10_kbd", keyboard, pressed(80'd1 << 16));

        // Short low glitch must not start a frame
        line = 1'b0;
        repeat (4) @(negedge clk);
        idle(10);
        check("glitch_cnt", 80'(valid_cnt), 80'd7);
        check("glitch_err", 80'(err_cnt), 80'd1);
        send(8'h21, 1'b1);
        idle(4);
        check("p21_byte", 80'(rx_byte), 80'h21);
        check("p21_kbd", keyboard, pressed((80'd1 << 16) | (80'd1 << 33)));

        // Back-to-back frames, 0x50 is an ignored code
        send(8'h01, 1'b1);
        send(8'h50, 1'b1);
        send(8'h02, 1'b1);
        idle(4);
        check("b2b_cnt", 80'(valid_cnt), 80'd11);
        check("b2b_log0", 80'(log_q[8]), 80'h01);
        check("b2b_log1", 80'(log_q[9]), 80'h50);
        check("b2b_log2", 80'(log_q[10]), 80'h02);
        check("b2b_kbd", keyboard,
              pressed((80'd1 << 16) | (80'd1 << 33) | (80'd1 << 1) | (80'd1 << 2)));

        // Fourth frame 0x44 cut short by reset during bit 2 (line high)
        line = 1'b0;
        repeat (3 * Div) @(negedge clk);
        line = 1'b1;
        repeat (Div / 2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(30);
        check("rst_kbd", keyboard, '1);
        check("rst_byte", 80'(rx_byte), 80'h00);
        check("rst_cnt", 80'(valid_cnt), 80'd11);
        check("rst_err", 80'(err_cnt), 80'd1);
        send(8'h03, 1'b1);
        idle(4);
        check("p03_byte", 80'(rx_byte), 80'h03);
        check("p03_kbd", keyboard, pressed(80'd1 << 3));
        check("p03_cnt", 80'(valid_cnt), 80'd12);
        check("overlap", 80'(overlap_cnt), 80'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
